// File: rtl/uart_tx_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_param_if
//  Purpose  : Word handshake between the transmit buffer (master) and the
//             parametrised UART transmitter (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] data_in;

  modport master (output tx_valid, output data_in, input tx_ready);
  modport slave  (input tx_valid, input data_in, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_param
//  Purpose  : Parametrised UART transmitter. Frames one word as start bit,
//             DATA_BITS data bits LSB-first, optional parity, 1 or 2 stop
//             bits, with an internal baud divider and a clock enable.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1
) (
  input  wire logic        tx_clk,
  input  wire logic        rst,
  input  wire logic        tx_enabled,
  uart_tx_param_if.slave   host,
  output logic             out,
  output logic             tx_busy,
  output logic             tx_done
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);
  localparam bit                HAS_PAR   = (PARITY_MODE != 0);
  localparam bit                ODD_PAR   = (PARITY_MODE == 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Refuse to elaborate with an unsupported frame format.
  if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 2 ||
      PARITY_MODE < 0 || PARITY_MODE > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
    $error("uart_tx_param: illegal parameter value");
  end

  logic [2:0]           state;
  logic [2:0]           state_next;
  logic [BAUD_W-1:0]    baud;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 parity_bit;
  logic                 out_next;
  logic                 shift_adv;
  logic                 done_next;
  logic                 wrap;
  logic                 accept;

  // A bit boundary only exists on an enabled cycle, so everything that is
  // keyed on wrap freezes automatically while tx_enabled is low.
  assign wrap          = tx_enabled && (baud == BAUD_LAST);
  assign host.tx_ready = (state == S_IDLE) && tx_enabled && !rst;
  assign accept        = host.tx_valid && host.tx_ready;

  // State register.
  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state decode: every frame state advances on the baud wrap.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (accept) state_next = S_START;
      S_START:  if (wrap) state_next = S_DATA;
      S_DATA:   if (wrap && bit_cnt == DATA_LAST)
                  state_next = HAS_PAR ? S_PARITY : S_STOP;
      S_PARITY: if (wrap) state_next = S_STOP;
      S_STOP:   if (wrap && bit_cnt == STOP_LAST) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Output decode: value the serial line takes on the coming edge.
  // Shifting happens when entering DATA and at each inner data-bit boundary,
  // so shift[0] is always the next data bit to drive.
  always_comb begin
    out_next  = out;
    shift_adv = wrap && ((state == S_START) ||
                         (state == S_DATA && bit_cnt != DATA_LAST));
    done_next = (state == S_STOP) && (state_next == S_IDLE);
    if (shift_adv) begin
      out_next = shift[0];
    end else if (state_next != state) begin
      case (state_next)
        S_IDLE:   out_next = 1'b1;
        S_START:  out_next = 1'b0;
        S_PARITY: out_next = parity_bit;
        S_STOP:   out_next = 1'b1;
        default:  out_next = out;
      endcase
    end
  end

  // Datapath: serial output, status flags, baud/bit counters, shift register.
  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      out        <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      baud       <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
    end else begin
      tx_done <= done_next;
      if (tx_enabled) begin
        out     <= out_next;
        tx_busy <= (state_next != S_IDLE);
        if (state == S_IDLE || baud == BAUD_LAST) baud <= '0;
        else                                     baud <= baud + BAUD_W'(1);
        if (state_next != state) bit_cnt <= '0;
        else if (wrap)           bit_cnt <= bit_cnt + 4'd1;
        if (accept) begin
          shift      <= host.data_in;
          parity_bit <= (^host.data_in) ^ ODD_PAR;
        end else if (shift_adv) begin
          shift <= shift >> 1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_param
//  Purpose  : Scoreboard bench for uart_tx_param across three frame formats
//             (8E1, 5O2, 8N1), all at four clocks per bit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_param;

  localparam int CPB = 4;

  typedef struct {
    int          dut;
    logic [15:0] bits;   // frame bits, bit 0 is sent first
    int          nbits;
    int          gap;    // required idle samples before start, -1 = any
    bit          abort;  // frame is expected to be cut short by reset
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt [3] = '{0, 0, 0};
  frame_t sbq [$];

  wire [2:0] outs, busys, dones, readys;

  always #5 clk = ~clk;

  uart_tx_param_if #(.DATA_BITS(8)) if_a ();
  uart_tx_param_if #(.DATA_BITS(5)) if_b ();
  uart_tx_param_if #(.DATA_BITS(8)) if_c ();

  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(1)) dut_a (
    .tx_clk(clk), .rst(rst), .tx_enabled(en), .host(if_a.slave),
    .out(outs[0]), .tx_busy(busys[0]), .tx_done(dones[0]));
  uart_tx_param #(.DATA_BITS(5), .CLKS_PER_BIT(CPB), .PARITY_MODE(2), .STOP_BITS(2)) dut_b (
    .tx_clk(clk), .rst(rst), .tx_enabled(en), .host(if_b.slave),
    .out(outs[1]), .tx_busy(busys[1]), .tx_done(dones[1]));
  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .STOP_BITS(1)) dut_c (
    .tx_clk(clk), .rst(rst), .tx_enabled(en), .host(if_c.slave),
    .out(outs[2]), .tx_busy(busys[2]), .tx_done(dones[2]));

  assign readys = {if_c.tx_ready, if_b.tx_ready, if_a.tx_ready};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic frame_t mkf(input int d, input logic [15:0] b, input int n,
                                 input int g, input bit ab);
    frame_t f;
    f.dut = d; f.bits = b; f.nbits = n; f.gap = g; f.abort = ab;
    return f;
  endfunction

  task automatic set_in(input int d, input logic v, input logic [8:0] w);
    case (d)
      0: begin if_a.tx_valid = v; if_a.data_in = w[7:0]; end
      1: begin if_b.tx_valid = v; if_b.data_in = w[4:0]; end
      default: begin if_c.tx_valid = v; if_c.data_in = w[7:0]; end
    endcase
  endtask

  // Present a word, wait for tx_ready, queue its expected frame, return just
  // after the accepting edge with tx_valid still high.
  task automatic send(input int d, input logic [8:0] w, input frame_t f);
    int n;
    n = 0;
    @(negedge clk);
    set_in(d, 1'b1, w);
    while (readys[d] !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (readys[d] !== 1'b1) begin
      checks++; errors++;
      $display("FAIL d%0d_accept_timeout actual=0 required=1", d);
    end else begin
      sbq.push_back(f);
      @(posedge clk);
    end
  endtask

  task automatic drop(input int d);
    @(negedge clk);
    set_in(d, 1'b0, 9'h000);
  endtask

  task automatic wait_idle(input int d, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busys[d] === 1'b1 && n < 3000);
    if (busys[d] === 1'b1) begin
      checks++; errors++;
      $display("FAIL d%0d_frame_timeout actual=busy required=idle", d);
    end
  endtask

  // Monitor: decodes one DUT's serial line sample by sample and checks it
  // against the oldest queued frame.
  task automatic monitor(input int d);
    frame_t f;
    int     idx, gap, last;
    logic   prev;
    bit     aborted;
    gap = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        gap = 0;
      end else if (outs[d] === 1'b1) begin
        gap++;
      end else if (sbq.size() == 0 || sbq[0].dut != d) begin
        checks++; errors++;
        $display("FAIL d%0d_unexpected_frame actual=start required=idle", d);
        while (outs[d] !== 1'b1 && !rst) begin @(posedge clk); #1; end
        gap = 0;
      end else begin
        f = sbq.pop_front();
        if (f.gap >= 0) chk($sformatf("d%0d_idle_gap", d), gap, f.gap);
        last    = f.nbits * CPB;
        idx     = 0;
        aborted = 1'b0;
        forever begin
          if (idx < last) begin
            chk($sformatf("d%0d_out_s%0d", d, idx), outs[d], f.bits[idx / CPB]);
            chk($sformatf("d%0d_busy_s%0d", d, idx), busys[d], 1);
            chk($sformatf("d%0d_done_s%0d", d, idx), dones[d], 0);
            chk($sformatf("d%0d_ready_s%0d", d, idx), readys[d], 0);
          end else begin
            chk($sformatf("d%0d_done_end", d), dones[d], 1);
            chk($sformatf("d%0d_out_end", d), outs[d], 1);
            chk($sformatf("d%0d_busy_end", d), busys[d], 0);
            chk($sformatf("d%0d_ready_end", d), readys[d], 1);
            break;
          end
          prev = outs[d];
          forever begin
            @(posedge clk); #1;
            if (rst || en) break;
            chk($sformatf("d%0d_frozen_out_s%0d", d, idx), outs[d], prev);
            chk($sformatf("d%0d_frozen_done_s%0d", d, idx), dones[d], 0);
          end
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          idx++;
        end
        chk($sformatf("d%0d_aborted", d), aborted, f.abort);
        gap = 1;
      end
    end
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none
  end

  // Count tx_done pulses per DUT.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) if (dones[d] === 1'b1) done_cnt[d]++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    set_in(0, 1'b0, 9'h000);
    set_in(1, 1'b0, 9'h000);
    set_in(2, 1'b0, 9'h000);
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d_rst_out", d), outs[d], 1);
      chk($sformatf("d%0d_rst_busy", d), busys[d], 0);
      chk($sformatf("d%0d_rst_done", d), dones[d], 0);
      chk($sformatf("d%0d_rst_ready", d), readys[d], 0);
    end
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) chk($sformatf("d%0d_idle_ready", d), readys[d], 1);

    // 8N1, 0xA5: 0,1,0,1,0,0,1,0,1,1
    send(2, 9'h0A5, mkf(2, 16'b1101001010, 10, -1, 1'b0));
    drop(2); wait_idle(2, n);

    // 8E1, 0x07: even parity 1
    send(0, 9'h007, mkf(0, 16'b11000001110, 11, -1, 1'b0));
    drop(0); wait_idle(0, n);

    // 5O2, 0x07: odd parity 0
    send(1, 9'h007, mkf(1, 16'b110001110, 9, -1, 1'b0));
    drop(1); wait_idle(1, n);

    // 5O2, 0x1F: 0,1,1,1,1,1,0,1,1
    send(1, 9'h01F, mkf(1, 16'b110111110, 9, -1, 1'b0));
    drop(1); wait_idle(1, n);

    // Back-to-back 0x55 then 0xAA with tx_valid held: one idle sample between
    send(0, 9'h055, mkf(0, 16'b10010101010, 11, -1, 1'b0));
    send(0, 9'h0AA, mkf(0, 16'b10101010100, 11, 1, 1'b0));
    drop(0); wait_idle(0, n);

    // 0x3C with tx_enabled low for 7 edges (E18..E24) inside data bit 3
    send(0, 9'h03C, mkf(0, 16'b10001111000, 11, -1, 1'b0));
    drop(0);
    repeat (17) @(negedge clk);
    en = 1'b0;
    repeat (7) @(negedge clk);
    en = 1'b1;
    wait_idle(0, n);
    // 25 negedges already used; busy first reads 0 before edge 44+7+1
    chk("d0_stretched_len", 25 + n, 44 + 7 + 1);

    // Reset at cycle 10 of a 0x55 frame, then a clean 0x0F frame
    send(0, 9'h055, mkf(0, 16'b10010101010, 11, -1, 1'b1));
    drop(0);
    repeat (9) @(negedge clk);
    chk("d0_pre_rst_out", outs[0], 0);
    rst = 1'b1;
    #1;
    chk("d0_async_rst_out", outs[0], 1);
    chk("d0_async_rst_busy", busys[0], 0);
    chk("d0_async_rst_done", dones[0], 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send(0, 9'h00F, mkf(0, 16'b10000011110, 11, -1, 1'b0));
    drop(0); wait_idle(0, n);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    chk("d0_done_pulses", done_cnt[0], 5);
    chk("d1_done_pulses", done_cnt[1], 2);
    chk("d2_done_pulses", done_cnt[2], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised successor to the fixed 8E1 UART transmitter. It serialises one word per frame in the form start bit, DATA_BITS data bits LSB-first, an optional parity bit, then 1 or 2 stop bits. An internal baud divider times each bit, and a valid/ready handshake accepts words from an upstream FIFO or CPU register. It sits between the transmit buffer and the serial pad driver.

Parameters:
- DATA_BITS, 8: data word width; legal values 5..9.
- CLKS_PER_BIT, 16: tx_clk enabled cycles per serial bit; minimum 2.
- PARITY_MODE, 1: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: number of stop bits; 1 or 2.

Ports:
- tx_clk, input, 1: single clock; all flops on its rising edge.
- rst, input, 1: reset, asynchronous and active-high.
- tx_enabled, input, 1: global clock-enable. When low, all state and counters freeze and `out` holds.
- tx_valid, input, 1: upstream has a word on data_in.
- data_in, input, DATA_BITS: word to transmit; sampled only on acceptance.
- tx_ready, output, 1: block can accept a word.
- out, output, 1: serial line; idle level 1.
- tx_busy, output, 1: a frame is in progress.
- tx_done, output, 1: one-cycle pulse when a frame completes.

Behaviour:
- Reset (asynchronous, rst=1):
  - state = IDLE.
  - out = 1, tx_busy = 0, tx_done = 0.
  - Baud counter, bit counter and shift register = 0.
  - tx_ready follows its combinational definition during reset.
- tx_ready = (state == IDLE) & tx_enabled & ~rst. It is combinational from state.
- Acceptance happens on a rising edge with tx_valid & tx_ready:
  - data_in is latched into the shift register.
  - The parity bit is computed from the latched word. Even mode: XOR of the data bits. Odd mode: the inverse of that.
  - State goes to START and tx_busy = 1 from the next cycle.
- Frame states (out is registered and changes on state entry):
  - IDLE: out = 1.
  - START: out = 0.
  - DATA: out = shift[0]; the shift register moves right once per bit.
  - PARITY: out = parity bit. This state is skipped when PARITY_MODE = 0.
  - STOP: out = 1 for STOP_BITS bits.
- Bit timing:
  - Each bit lasts exactly CLKS_PER_BIT cycles with tx_enabled = 1.
  - The baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - A new state is entered on the wrap cycle.
- Bit counter: counts 0..DATA_BITS-1 in DATA and 0..STOP_BITS-1 in STOP. It is cleared on every state change.
- Frame length = (1 + DATA_BITS + P + STOP_BITS) × CLKS_PER_BIT enabled cycles, where P = (PARITY_MODE != 0).
- Frame end:
  - At the wrap of the last stop bit the state returns to IDLE.
  - tx_done = 1 for exactly that one cycle; tx_busy = 0 on the same edge.
- Back-to-back frames: if tx_valid is high in the first IDLE cycle, the word is accepted immediately. This leaves a minimum of one tx_clk cycle of out = 1 between frames.
- tx_enabled = 0:
  - Counters, state and out hold.
  - tx_done does not pulse.
  - No acceptance occurs, because tx_ready = 0.
  - Operation resumes exactly where it stopped when tx_enabled returns to 1.
- Changes to data_in or tx_valid during a frame have no effect.
- Reset mid-frame: out goes to 1 immediately and asynchronously. The frame is abandoned with no tx_done pulse.
- Illegal parameter values (PARITY_MODE = 3, STOP_BITS outside 1..2) are rejected by an elaboration-time check.

Test Plan:
1. DATA_BITS=8, PARITY_MODE=0, STOP_BITS=1, CLKS_PER_BIT=4; send 0xA5 → out = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total); tx_done pulses once at cycle 40; tx_ready is low throughout the frame.
2. PARITY_MODE=1, send 0x07 → parity bit = 1. PARITY_MODE=2, send 0x07 → parity bit = 0. Frame length = 44 cycles at CLKS_PER_BIT=4.
3. DATA_BITS=5, STOP_BITS=2, send 0x1F → out = 0,1,1,1,1,1, then parity, then 1,1; 9 bits × 4 = 36 cycles.
4. Hold tx_valid high with two words 0x55 then 0xAA → both frames sent; exactly one idle cycle (out = 1) between them; two tx_done pulses.
5. Deassert tx_enabled for 7 cycles during data bit 3 → out frozen for those 7 cycles; the frame completes 7 cycles later than nominal with a correct bit sequence.
6. Assert rst at cycle 10 of a frame → out = 1 in the same cycle without waiting for a clock edge; tx_busy = 0; no tx_done; the next accepted word transmits normally.
